// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and helpers for the halfword-memory arbiter.
//   - size_e  : request size encoding (byte / halfword / word / reserved)
//   - state_e : arbiter sequencing states
//   - lane / beat constants and helpers that map a request onto one
//     16-bit memory beat (lane 0 = even byte, lane 1 = odd byte)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    localparam bit          LANE_EVEN  = 1'b0;
    localparam bit          LANE_ODD   = 1'b1;
    localparam int unsigned BEAT_BYTES = 2;

    // Reserved size, or a halfword/word that does not start on an even byte.
    function automatic logic is_illegal(input size_e size, input logic addr0);
        return (size == SZ_RSVD) || ((size != SZ_BYTE) && addr0);
    endfunction

    // Write data for one beat. A byte is replicated on both lanes so the
    // lane enable alone decides where it lands; beat 1 carries the upper
    // halfword of a word.
    function automatic logic [0:1][7:0] lane_data(input logic [31:0] wdata,
                                                  input size_e       size,
                                                  input logic        beat);
        logic [0:1][7:0] d;
        if (size == SZ_BYTE) begin
            d[LANE_EVEN] = wdata[7:0];
            d[LANE_ODD]  = wdata[7:0];
        end else if (beat) begin
            d[LANE_EVEN] = wdata[23:16];
            d[LANE_ODD]  = wdata[31:24];
        end else begin
            d[LANE_EVEN] = wdata[7:0];
            d[LANE_ODD]  = wdata[15:8];
        end
        return d;
    endfunction

    // Per-lane write enables: bytes touch only the lane picked by addr[0].
    function automatic logic [0:1] lane_en(input size_e size, input logic addr0);
        logic [0:1] en;
        if (size == SZ_BYTE) begin
            en        = '0;
            en[addr0] = 1'b1;
        end else begin
            en = '1;
        end
        return en;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select
//   Chooses which requesting port is granted when the arbiter is idle.
//   Build option MEM_ARB_RR_EN: defined -> round-robin, the search starts
//   at the port after the last granted one (pointer resets to port 0);
//   undefined -> fixed priority, lowest index wins, no pointer state.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_req      : per-port request vector
//   i_advance  : a grant is being taken this cycle (moves the pointer)
//   o_valid    : at least one port is requesting
//   o_idx      : index of the selected port
module mem_arb_select #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_advance,
    output logic                 o_valid,
    output logic [IDX_W-1:0]     o_idx
);

`ifdef MEM_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned cand;
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        o_valid = 1'b0;
        o_idx   = '0;
        cand    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (int'(ptr_q) + i) % NUM_PORTS;
            if (!o_valid && i_req[cand]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (i_advance && o_valid) begin
            ptr_d = IDX_W'((int'(o_idx) + 1) % NUM_PORTS);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst, i_advance};

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!o_valid && i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates NUM_PORTS requesters onto a 16-bit, 1-cycle synchronous
//   memory. Bytes and halfwords take one beat, words take two (low half
//   first). Misaligned or reserved-size requests are rejected with o_err
//   without touching memory. Arbitration happens only in IDLE.
//   Build option MEM_ARB_RR_EN selects round-robin (see mem_arb_select).
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   i_req/i_wr/i_size/i_addr/i_wdata : per-port command, held until ack
//   o_ack                       : one-cycle completion strobe per port
//   o_err, o_rdata              : response, valid with o_ack
//   o_busy                      : arbiter not idle
//   i_mem_do, o_mem_*           : memory beat interface (lane 0 = even byte)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int MEM_DEPTH  = 2**12,
    parameter  int NUM_PORTS  = 2,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 i_req,
    input  logic [NUM_PORTS-1:0]                 i_wr,
    input  logic [NUM_PORTS-1:0][1:0]            i_size,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_PORTS-1:0][31:0]           i_wdata,
    output logic [NUM_PORTS-1:0]                 o_ack,
    output logic                                 o_err,
    output logic [31:0]                          o_rdata,
    output logic                                 o_busy,
    input  logic [0:1][7:0]                      i_mem_do,
    output logic [0:1][7:0]                      o_mem_di,
    output logic [ADDR_WIDTH-1:0]                o_mem_addr,
    output logic                                 o_mem_en,
    output logic                                 o_mem_rd_en,
    output logic [0:1]                           o_mem_wr_en
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(2*MEM_DEPTH);

    // Beat 1 of a word sits two bytes up, wrapping at the end of memory.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic                  beat);
        logic [ADDR_WIDTH:0] sum;
        sum = {1'b0, base};
        if (beat) sum = sum + (ADDR_WIDTH+1)'(BEAT_BYTES);
        if (sum >= MEM_BYTES) sum = sum - MEM_BYTES;
        return sum[ADDR_WIDTH-1:0];
    endfunction

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       cmd_port_q, cmd_port_d;
    logic                   cmd_wr_q, cmd_wr_d;
    size_e                  cmd_size_q, cmd_size_d;
    logic [ADDR_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
    logic [31:0]            cmd_wdata_q, cmd_wdata_d;
    logic [15:0]            rdata_lo_q, rdata_lo_d;
    logic [NUM_PORTS-1:0]   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic [0:1]             mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [0:1][7:0]        mem_di_q, mem_di_d;

    logic                   sel_valid, sel_advance;
    logic [IDX_W-1:0]       sel_idx;

    mem_arb_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_select (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_advance (sel_advance),
        .o_valid   (sel_valid),
        .o_idx     (sel_idx)
    );

    logic                  win_wr;
    size_e                 win_size;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [31:0]           win_wdata;

    assign win_wr    = i_wr[sel_idx];
    assign win_size  = size_e'(i_size[sel_idx]);
    assign win_addr  = i_addr[sel_idx];
    assign win_wdata = i_wdata[sel_idx];

    // Source of the beat about to be issued: the winner's live inputs on
    // the grant edge, the captured command for beat 1 of a word.
    logic                  beat_go, beat_idx, src_wr;
    size_e                 src_size;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [31:0]           src_wdata;

    always_comb begin
        state_d     = state_q;
        cmd_port_d  = cmd_port_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_size_d  = cmd_size_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata_lo_d  = rdata_lo_q;
        ack_d       = '0;
        err_d       = 1'b0;
        sel_advance = 1'b0;
        beat_go     = 1'b0;
        beat_idx    = 1'b0;
        src_wr      = cmd_wr_q;
        src_size    = cmd_size_q;
        src_addr    = cmd_addr_q;
        src_wdata   = cmd_wdata_q;
        mem_en_d    = 1'b0;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = '0;
        mem_addr_d  = '0;
        mem_di_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    sel_advance = 1'b1;
                    cmd_port_d  = sel_idx;
                    cmd_wr_d    = win_wr;
                    cmd_size_d  = win_size;
                    cmd_addr_d  = win_addr;
                    cmd_wdata_d = win_wdata;
                    if (is_illegal(win_size, win_addr[0])) begin
                        state_d        = ST_RESP;
                        ack_d[sel_idx] = 1'b1;
                        err_d          = 1'b1;
                    end else begin
                        state_d   = ST_ACC0;
                        beat_go   = 1'b1;
                        src_wr    = win_wr;
                        src_size  = win_size;
                        src_addr  = win_addr;
                        src_wdata = win_wdata;
                    end
                end
            end
            ST_ACC0: begin
                if (cmd_size_q == SZ_WORD) begin
                    state_d  = ST_ACC1;
                    beat_go  = 1'b1;
                    beat_idx = 1'b1;
                end else begin
                    state_d           = ST_RESP;
                    ack_d[cmd_port_q] = 1'b1;
                end
            end
            ST_ACC1: begin
                // Beat-0 read data arrives now; beat 1 arrives in RESP.
                if (!cmd_wr_q) rdata_lo_d = {i_mem_do[LANE_ODD], i_mem_do[LANE_EVEN]};
                state_d           = ST_RESP;
                ack_d[cmd_port_q] = 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (beat_go) begin
            mem_en_d    = 1'b1;
            mem_rd_en_d = !src_wr;
            mem_addr_d  = beat_addr(src_addr, beat_idx);
            if (src_wr) begin
                mem_wr_en_d = lane_en(src_size, src_addr[0]);
                mem_di_d    = lane_data(src_wdata, src_size, beat_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_port_q  <= '0;
            cmd_wr_q    <= 1'b0;
            cmd_size_q  <= SZ_BYTE;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata_lo_q  <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= '0;
            mem_addr_q  <= '0;
            mem_di_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_port_q  <= cmd_port_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_size_q  <= cmd_size_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata_lo_q  <= rdata_lo_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            mem_en_q    <= mem_en_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_di_q    <= mem_di_d;
        end
    end

    // Read data is assembled from the memory output in RESP itself, since
    // the last beat only becomes valid in that cycle.
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (state_q == ST_RESP && !err_q && !cmd_wr_q) begin
            case (cmd_size_q)
                SZ_BYTE: rdata = {24'b0, i_mem_do[cmd_addr_q[0]]};
                SZ_HALF: rdata = {16'b0, i_mem_do[LANE_ODD], i_mem_do[LANE_EVEN]};
                SZ_WORD: rdata = {i_mem_do[LANE_ODD], i_mem_do[LANE_EVEN], rdata_lo_q};
                default: rdata = '0;
            endcase
        end
    end

    assign o_ack       = ack_q;
    assign o_err       = err_q;
    assign o_rdata     = rdata;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_mem_en    = mem_en_q;
    assign o_mem_rd_en = mem_rd_en_q;
    assign o_mem_wr_en = mem_wr_en_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_di    = mem_di_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter (MEM_DEPTH=64, NUM_PORTS=2).
//   A byte-array reference model gives expected read data, errors and
//   latencies; a 1-cycle synchronous memory model serves the DUT.
module tb_mem_arbiter;

    localparam int D  = 64;
    localparam int N  = 2;
    localparam int AW = $clog2(D*2);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         i_req, i_wr;
    logic [N-1:0][1:0]    i_size;
    logic [N-1:0][AW-1:0] i_addr;
    logic [N-1:0][31:0]   i_wdata;
    logic [N-1:0]         o_ack;
    logic                 o_err, o_busy;
    logic [31:0]          o_rdata;
    logic [0:1][7:0]      i_mem_do = '0;
    logic [0:1][7:0]      o_mem_di;
    logic [AW-1:0]        o_mem_addr;
    logic                 o_mem_en, o_mem_rd_en;
    logic [0:1]           o_mem_wr_en;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.MEM_DEPTH(D), .NUM_PORTS(N)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_wr(i_wr), .i_size(i_size),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_ack(o_ack), .o_err(o_err),
        .o_rdata(o_rdata), .o_busy(o_busy), .i_mem_do(i_mem_do),
        .o_mem_di(o_mem_di), .o_mem_addr(o_mem_addr), .o_mem_en(o_mem_en),
        .o_mem_rd_en(o_mem_rd_en), .o_mem_wr_en(o_mem_wr_en)
    );

    always #5 clk = ~clk;

    // Reference byte memory (written only by the model) and the memory the
    // DUT talks to, which reloads from the reference while rst is high.
    logic [7:0] ref_b [2*D];
    logic [7:0] mem_b [2*D];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2*D; i++) mem_b[i] <= ref_b[i];
        end else if (o_mem_en) begin
            if (o_mem_rd_en) begin
                i_mem_do[0] <= mem_b[{o_mem_addr[AW-1:1], 1'b0}];
                i_mem_do[1] <= mem_b[{o_mem_addr[AW-1:1], 1'b1}];
            end
            if (o_mem_wr_en[0]) mem_b[{o_mem_addr[AW-1:1], 1'b0}] <= o_mem_di[0];
            if (o_mem_wr_en[1]) mem_b[{o_mem_addr[AW-1:1], 1'b1}] <= o_mem_di[1];
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   di;   // di[7:0] = lane 0
        logic [1:0]    we;   // we[0]   = lane 0
        logic          rd;
    } beat_t;

    beat_t beats[$];

    // Expected outcome of one transaction from the byte-level rules.
    function automatic void ref_txn(input logic wr, input logic [1:0] sz,
                                    input logic [AW-1:0] a, input logic [31:0] wd,
                                    output int lat, output logic err,
                                    output logic [31:0] rd);
        int nb;
        int idx;
        rd  = '0;
        err = 1'b0;
        if (sz == 2'b11 || (sz != 2'b00 && a[0])) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        nb  = 1 << sz;
        lat = (sz == 2'b10) ? 3 : 2;
        for (int k = 0; k < nb; k++) begin
            idx = (int'(a) + k) % (2*D);
            if (wr) ref_b[idx] = wd[8*k +: 8];
            else    rd[8*k +: 8] = ref_b[idx];
        end
    endfunction

    // Issue one request and observe the response; inputs are scrambled
    // after the grant edge, which must not affect the result.
    task automatic run_txn(input int p, input logic wr, input logic [1:0] sz,
                           input logic [AW-1:0] a, input logic [31:0] wd,
                           output int lat, output logic [N-1:0] ackv,
                           output logic errv, output logic [31:0] rdv);
        beats.delete();
        lat  = -1;
        ackv = '0;
        errv = 1'b0;
        rdv  = '0;
        @(negedge clk);
        i_req[p] = 1'b1; i_wr[p] = wr; i_size[p] = sz; i_addr[p] = a; i_wdata[p] = wd;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (o_mem_en === 1'b1)
                beats.push_back('{o_mem_addr, {o_mem_di[1], o_mem_di[0]},
                                  {o_mem_wr_en[1], o_mem_wr_en[0]}, o_mem_rd_en});
            if (n == 1) begin
                i_wr[p] = ~wr; i_size[p] = 2'($urandom);
                i_addr[p] = AW'($urandom); i_wdata[p] = $urandom;
            end
            if (o_ack !== '0) begin
                lat = n; ackv = o_ack; errv = o_err; rdv = o_rdata;
                break;
            end
        end
        i_req[p] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_ack, o_err, o_rdata, o_busy, o_mem_en, o_mem_rd_en, o_mem_wr_en,
             o_mem_addr, o_mem_di} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b err=%b rdata=%h busy=%b en=%b exp all 0",
                     o_ack, o_err, o_rdata, o_busy, o_mem_en);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_busy, o_ack, o_mem_en} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b ack=%b en=%b exp 0", o_busy, o_ack, o_mem_en);
        end
    endtask

    task automatic test_half_read();
        int lat; logic [N-1:0] ackv; logic errv; logic [31:0] rdv;
        run_txn(0, 1'b0, 2'b01, AW'(16), 32'h0, lat, ackv, errv, rdv);
        checks++;
        if (lat !== 2 || ackv !== 2'b01 || errv !== 1'b0) begin
            errors++;
            $display("FAIL half_read_ack: got lat=%0d ack=%b err=%b exp lat=2 ack=01 err=0", lat, ackv, errv);
        end
        checks++;
        if (rdv !== 32'h0000_1234) begin
            errors++;
            $display("FAIL half_read_data: got %h exp 00001234", rdv);
        end
        checks++;
        if (beats.size() != 1 || beats[0].addr !== AW'(16) || beats[0].rd !== 1'b1 || beats[0].we !== 2'b00) begin
            errors++;
            $display("FAIL half_read_beat: got n=%0d exp one read beat at 10", beats.size());
        end
    endtask

    task automatic test_word_write();
        int lat, elat; logic [N-1:0] ackv; logic errv, eerr; logic [31:0] rdv, erd;
        ref_txn(1'b1, 2'b10, AW'(32), 32'hDEAD_BEEF, elat, eerr, erd);
        run_txn(1, 1'b1, 2'b10, AW'(32), 32'hDEAD_BEEF, lat, ackv, errv, rdv);
        checks++;
        if (lat !== 3 || ackv !== 2'b10 || errv !== 1'b0) begin
            errors++;
            $display("FAIL word_write_ack: got lat=%0d ack=%b err=%b exp lat=3 ack=10 err=0", lat, ackv, errv);
        end
        checks++;
        if (beats.size() != 2) begin
            errors++;
            $display("FAIL word_write_beats: got %0d beats exp 2", beats.size());
        end else begin
            checks++;
            if ({beats[0].addr, beats[0].di, beats[0].we, beats[0].rd} !== {AW'(32), 16'hBEEF, 2'b11, 1'b0}) begin
                errors++;
                $display("FAIL word_write_beat0: got addr=%h di=%h we=%b exp addr=20 di=beef we=11",
                         beats[0].addr, beats[0].di, beats[0].we);
            end
            checks++;
            if ({beats[1].addr, beats[1].di, beats[1].we, beats[1].rd} !== {AW'(34), 16'hDEAD, 2'b11, 1'b0}) begin
                errors++;
                $display("FAIL word_write_beat1: got addr=%h di=%h we=%b exp addr=22 di=dead we=11",
                         beats[1].addr, beats[1].di, beats[1].we);
            end
        end
        run_txn(0, 1'b0, 2'b10, AW'(32), 32'h0, lat, ackv, errv, rdv);
        checks++;
        if (rdv !== 32'hDEAD_BEEF || lat !== 3) begin
            errors++;
            $display("FAIL word_readback: got %h lat=%0d exp deadbeef lat=3", rdv, lat);
        end
    endtask

    task automatic test_byte_write();
        int lat, elat; logic [N-1:0] ackv; logic errv, eerr; logic [31:0] rdv, erd;
        ref_txn(1'b1, 2'b00, AW'(49), 32'h0000_005A, elat, eerr, erd);
        run_txn(0, 1'b1, 2'b00, AW'(49), 32'h0000_005A, lat, ackv, errv, rdv);
        checks++;
        if (lat !== 2 || ackv !== 2'b01 || errv !== 1'b0) begin
            errors++;
            $display("FAIL byte_write_ack: got lat=%0d ack=%b err=%b exp lat=2 ack=01 err=0", lat, ackv, errv);
        end
        checks++;
        if (beats.size() != 1 || beats[0].addr !== AW'(49) || beats[0].we !== 2'b10 || beats[0].di[15:8] !== 8'h5A) begin
            errors++;
            $display("FAIL byte_write_beat: got n=%0d we=%b di=%h exp one beat we=10 (lane1 only) di[1]=5a",
                     beats.size(), (beats.size() > 0) ? beats[0].we : 2'bxx,
                     (beats.size() > 0) ? beats[0].di : 16'hxxxx);
        end
        ref_txn(1'b0, 2'b01, AW'(48), 32'h0, elat, eerr, erd);
        run_txn(1, 1'b0, 2'b01, AW'(48), 32'h0, lat, ackv, errv, rdv);
        checks++;
        if (rdv !== erd) begin
            errors++;
            $display("FAIL byte_write_readback: got %h exp %h", rdv, erd);
        end
    endtask

    task automatic test_misaligned();
        int lat; logic [N-1:0] ackv; logic errv; logic [31:0] rdv;
        run_txn(0, 1'b0, 2'b01, AW'(3), 32'h0, lat, ackv, errv, rdv);
        checks++;
        if (lat !== 1 || ackv !== 2'b01 || errv !== 1'b1 || rdv !== '0 || beats.size() != 0) begin
            errors++;
            $display("FAIL misaligned_half: got lat=%0d ack=%b err=%b beats=%0d exp lat=1 ack=01 err=1 beats=0",
                     lat, ackv, errv, beats.size());
        end
        run_txn(1, 1'b1, 2'b11, AW'(8), 32'h1234_5678, lat, ackv, errv, rdv);
        checks++;
        if (lat !== 1 || ackv !== 2'b10 || errv !== 1'b1 || beats.size() != 0) begin
            errors++;
            $display("FAIL reserved_size: got lat=%0d ack=%b err=%b beats=%0d exp lat=1 ack=10 err=1 beats=0",
                     lat, ackv, errv, beats.size());
        end
    endtask

    task automatic test_wrap();
        int lat, elat; logic [N-1:0] ackv; logic errv, eerr; logic [31:0] rdv, erd, wd;
        wd = $urandom;
        ref_txn(1'b1, 2'b10, AW'(2*D-2), wd, elat, eerr, erd);
        run_txn(0, 1'b1, 2'b10, AW'(2*D-2), wd, lat, ackv, errv, rdv);
        checks++;
        if (beats.size() != 2 || beats[1].addr !== AW'(0)) begin
            errors++;
            $display("FAIL wrap_beat1_addr: got n=%0d addr=%h exp 2 beats, beat1 addr 0",
                     beats.size(), (beats.size() > 1) ? beats[1].addr : AW'('1));
        end
        ref_txn(1'b0, 2'b10, AW'(2*D-2), 32'h0, elat, eerr, erd);
        run_txn(1, 1'b0, 2'b10, AW'(2*D-2), 32'h0, lat, ackv, errv, rdv);
        checks++;
        if (rdv !== erd || rdv !== wd) begin
            errors++;
            $display("FAIL wrap_readback: got %h exp %h", rdv, erd);
        end
    endtask

    task automatic test_random();
        int p, lat, elat; logic wr, eerr, errv; logic [1:0] sz;
        logic [AW-1:0] a; logic [31:0] wd, erd, rdv; logic [N-1:0] ackv;
        for (int t = 0; t < 60; t++) begin
            p  = $urandom_range(0, N-1);
            wr = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            a  = AW'($urandom_range(0, 2*D-1));
            if (sz != 2'b00 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
            wd = $urandom;
            ref_txn(wr, sz, a, wd, elat, eerr, erd);
            run_txn(p, wr, sz, a, wd, lat, ackv, errv, rdv);
            checks++;
            if (lat !== elat || ackv !== N'(1 << p) || errv !== eerr || rdv !== erd) begin
                errors++;
                $display("FAIL random_%0d: got lat=%0d ack=%b err=%b rdata=%h exp lat=%0d ack=%b err=%b rdata=%h (wr=%b sz=%b a=%h)",
                         t, lat, ackv, errv, rdv, elat, N'(1 << p), eerr, erd, wr, sz, a);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] got[$];
        int at[$];
        logic [N-1:0] exp_ack;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < N; p++) begin
            i_req[p] = 1'b1; i_wr[p] = 1'b0; i_size[p] = 2'b01;
            i_addr[p] = AW'(2 * $urandom_range(0, D-1)); i_wdata[p] = '0;
        end
        for (int n = 1; n <= 40 && got.size() < 4; n++) begin
            @(negedge clk);
            if (o_ack !== '0) begin
                got.push_back(o_ack);
                at.push_back(n);
            end
        end
        i_req = '0;
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d grants exp 4", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
`ifdef MEM_ARB_RR_EN
            exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_ack = 2'b01;
`endif
            checks++;
            if (got[k] !== exp_ack) begin
                errors++;
                $display("FAIL b2b_grant_%0d: got %b exp %b", k, got[k], exp_ack);
            end
            if (k > 0) begin
                checks++;
                if (at[k] - at[k-1] != 3) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: got %0d cycles exp 3", k, at[k] - at[k-1]);
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        int acks = 0;
        @(negedge clk);
        i_req[0] = 1'b1; i_wr[0] = 1'b0; i_size[0] = 2'b10; i_addr[0] = AW'(32);
        repeat (2) @(negedge clk);
        checks++;
        if ({o_busy, o_mem_en, o_mem_addr} !== {1'b1, 1'b1, AW'(34)}) begin
            errors++;
            $display("FAIL midflight_acc1: got busy=%b en=%b addr=%h exp 1 1 22", o_busy, o_mem_en, o_mem_addr);
        end
        rst = 1'b1;
        i_req = '0;
        @(negedge clk);
        checks++;
        if ({o_ack, o_err, o_rdata, o_busy, o_mem_en, o_mem_rd_en, o_mem_wr_en,
             o_mem_addr, o_mem_di} !== '0) begin
            errors++;
            $display("FAIL midflight_reset: got ack=%b busy=%b en=%b rdata=%h exp all 0",
                     o_ack, o_busy, o_mem_en, o_rdata);
        end
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (o_ack !== '0) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL midflight_no_ack: got %0d acks exp 0", acks);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_req = '0; i_wr = '0; i_size = '0; i_addr = '0; i_wdata = '0;
        for (int i = 0; i < 2*D; i++) ref_b[i] = 8'($urandom);
        ref_b[16] = 8'h34;
        ref_b[17] = 8'h12;
        test_reset();
        test_half_read();
        test_word_write();
        test_byte_write();
        test_misaligned();
        test_wrap();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
